tick_watchdog: RTL and testbench
================================

# tick_watchdog

Periodic-tick watchdog sitting directly downstream of the delay/tick generator. Consumes its one-cycle `sig` pulse as `tick`, measures the gap between consecutive ticks, and flags a fault when a tick is late (timeout) or, optionally, early. Provides a sticky fault with a cause code, a saturating fault counter and the last measured gap, for the system-level supervisor.

## Interface
- `MIN_GAP`, default 746: smallest legal tick-to-tick gap in clk cycles.
- `MAX_GAP`, default 756: largest legal gap. The default upstream period is 751.
- `CBITS`, default 10: gap counter width.
- `FCNT_W`, default 8: fault counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle tick pulse from upstream.
- `clr` in 1: clears a latched fault.
- `ok` out 1: high while in RUN, i.e. a tick has been seen and no fault has occurred since.
- `fault` out 1: sticky fault flag.
- `fault_code` out 2: fault cause. 00 = none, 01 = late, 10 = early, 11 = reserved, never driven.
- `fault_cnt` out FCNT_W: number of FAULT entries, saturating.
- `gap` out CBITS: last accepted gap.

## Operation
- Gap counter `cnt` holds the number of cycles since the last accepted tick. It loads 1 on the cycle after a tick, then increments by 1 per cycle, saturating at 2^CBITS−1. A tick g cycles after the previous one sees `cnt == g`.
- Legality: 1 ≤ MIN_GAP ≤ MAX_GAP < 2^CBITS−1. Illegal values are an elaboration error.
- **IDLE** (after reset or clr):
  - no timeout is checked;
  - on `tick`: go to RUN, `cnt` <= 1.
- **RUN**: `ok` = 1.
  - `tick` with `cnt` in [MIN_GAP, MAX_GAP]: `gap` <= `cnt`, `cnt` <= 1, stay in RUN.
  - `tick` with `cnt` < MIN_GAP: early fault, only when the feature is enabled (see Configuration).
  - No `tick` with `cnt == MAX_GAP`: late fault, code 01. A tick arriving on that same cycle is legal and takes priority.
- **FAULT**:
  - `fault` = 1, `ok` = 0, `fault_code` held;
  - `tick` is ignored;
  - `clr` returns to IDLE and sets `fault_code` to 00; `fault_cnt` and `gap` are held.
- On `clr` with `tick` in the same cycle while in FAULT: go to IDLE and ignore that tick; the next tick arms.
- `clr` outside FAULT has no effect.
- `fault_cnt` increments by 1 on each FAULT entry and saturates at 2^FCNT_W−1. Only `rst` clears it.
- `rst` has priority over everything, including mid-RUN and in FAULT.

## Timing
- All outputs are registered.
- Reset values: `ok` 0, `fault` 0, `fault_code` 00, `fault_cnt` 0, `gap` 0, state IDLE, `cnt` 0.
- Detection latency is 1 cycle:
  - a condition sampled at edge k is visible on the outputs after edge k+1;
  - `ok` rises the cycle after the first tick;
  - `gap` updates the cycle after the accepted tick.
- A late fault is visible exactly MAX_GAP+1 cycles after the last accepted tick.
- `rst` takes effect at the next edge; outputs hold reset values from the following cycle.

## Configuration
- `TICK_WDOG_EARLY_CHECK_EN` defined:
  - a tick in RUN with `cnt` < MIN_GAP enters FAULT with code 10;
  - `gap` is not updated.
- `TICK_WDOG_EARLY_CHECK_EN` not defined:
  - an early tick is accepted like a legal one (`gap` <= `cnt`, `cnt` <= 1);
  - code 10 is never produced;
  - MIN_GAP is unused except in the legality check.

## Structure
- Package `tick_wdog_pkg` contains:
  - state enum `wdog_state_t` {IDLE, RUN, FAULT};
  - fault code enum `wdog_fault_t` {FC_NONE, FC_LATE, FC_EARLY, FC_RSVD}, 2 bits.
- One sub-module, `sat_counter`: parameterised width, `inc` and synchronous `clr`, saturating. It is instantiated for `fault_cnt`. The gap counter is inline.

## Test plan
- Reset, then ticks every 751 cycles ×4 -> `ok` = 1 from the cycle after the first tick; `gap` = 751; `fault` = 0; `fault_cnt` = 0.
- Gaps of exactly 746 and 756 -> both accepted, `gap` shows 746 then 756, no fault. A gap of 757 -> `fault` = 1, code 01, 757 cycles after the tick; `fault_cnt` = 1.
- Gap of 700:
  - with `TICK_WDOG_EARLY_CHECK_EN` -> `fault` = 1, code 10, `gap` keeps its previous value;
  - without it -> `gap` = 700, `ok` stays 1.
- In FAULT, `clr` and `tick` in the same cycle -> IDLE, `ok` = 0, `fault` = 0, code 00; the next tick sets `ok` = 1 one cycle later.
- `rst` asserted in RUN at `cnt` = 400 -> all outputs at reset values the following cycle, state IDLE, no fault on later silence.
- FCNT_W = 4, 20 late-fault/clr cycles -> `fault_cnt` saturates at 15.

Source files
------------

// File: rtl/tick_watchdog_pkg.sv
// tick_wdog_pkg: shared types for the tick watchdog.
//   wdog_state_t : watchdog FSM state (IDLE, RUN, FAULT)
//   wdog_fault_t : fault cause code driven on fault_code
package tick_wdog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } wdog_state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_LATE  = 2'b01,
        FC_EARLY = 2'b10,
        FC_RSVD  = 2'b11  // reserved, never driven
    } wdog_fault_t;

endpackage

// File: rtl/tick_watchdog_if.sv
// tick_watchdog_if: tick input, clear and status outputs of the tick watchdog.
//   master : supervisor / upstream side (drives tick, clr; observes status)
//   slave  : watchdog side
//   tick, clr            : one-cycle tick pulse, fault clear
//   ok, fault            : in RUN / sticky fault
//   fault_code           : 00 none, 01 late, 10 early
//   fault_cnt, gap       : saturating FAULT entry count, last accepted gap
interface tick_watchdog_if #(
    parameter int unsigned CBITS  = 10,
    parameter int unsigned FCNT_W = 8
);
    logic              tick;
    logic              clr;
    logic              ok;
    logic              fault;
    logic [1:0]        fault_code;
    logic [FCNT_W-1:0] fault_cnt;
    logic [CBITS-1:0]  gap;

    modport master (
        output tick, clr,
        input  ok, fault, fault_code, fault_cnt, gap
    );

    modport slave (
        input  tick, clr,
        output ok, fault, fault_code, fault_cnt, gap
    );
endinterface

// File: rtl/tick_watchdog_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : increment by one (ignored when saturated)
//   clr_i    : synchronous clear, wins over inc_i
//   cnt_o    : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/tick_watchdog.sv
// tick_watchdog: measures the gap between consecutive upstream ticks and latches a
// sticky fault when a tick is late (or early, when enabled).
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : tick_watchdog_if.slave (tick, clr in; ok, fault, fault_code,
//              fault_cnt, gap out)
// Build option: define TICK_WDOG_EARLY_CHECK_EN to fault (code 10) on ticks that
// arrive with cnt < MIN_GAP; otherwise such ticks are accepted as legal.
module tick_watchdog
    import tick_wdog_pkg::*;
#(
    parameter int unsigned MIN_GAP = 746,
    parameter int unsigned MAX_GAP = 756,
    parameter int unsigned CBITS   = 10,
    parameter int unsigned FCNT_W  = 8
) (
    input logic            clk,
    input logic            rst,
    tick_watchdog_if.slave bus_io
);
    // cnt must be able to reach MAX_GAP without saturating first.
    if ((MIN_GAP < 1) || (MIN_GAP > MAX_GAP) ||
        (64'(MAX_GAP) >= ((64'(1) << CBITS) - 64'(1)))) begin : g_bad_params
        $error("tick_watchdog: illegal MIN_GAP/MAX_GAP/CBITS combination");
    end

    localparam logic [CBITS-1:0] MaxGapC = CBITS'(MAX_GAP);
    localparam logic [CBITS-1:0] CntSat  = {CBITS{1'b1}};

    wdog_state_t      state_q, state_d;
    wdog_fault_t      code_q, code_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] gap_q, gap_d;
    logic             early;
    logic             enter_fault;

`ifdef TICK_WDOG_EARLY_CHECK_EN
    assign early = (cnt_q < CBITS'(MIN_GAP));
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.tick) begin
                    state_d = RUN;
                    cnt_d   = CBITS'(1);
                end
            end
            RUN: begin
                cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CBITS'(1);
                // A tick on the MAX_GAP cycle is legal and beats the timeout.
                if (bus_io.tick && early) begin
                    state_d = FAULT;
                    code_d  = FC_EARLY;
                end else if (bus_io.tick) begin
                    gap_d = cnt_q;
                    cnt_d = CBITS'(1);
                end else if (cnt_q == MaxGapC) begin
                    state_d = FAULT;
                    code_d  = FC_LATE;
                end
            end
            FAULT: begin
                // Any tick in the clearing cycle is dropped; the next one arms.
                if (bus_io.clr) begin
                    state_d = IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign enter_fault = (state_d == FAULT) && (state_q != FAULT);

    // fault_cnt survives clr; only reset clears it.
    sat_counter #(
        .W (FCNT_W)
    ) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (enter_fault),
        .clr_i (1'b0),
        .cnt_o (bus_io.fault_cnt)
    );

    assign bus_io.ok         = (state_q == RUN);
    assign bus_io.fault      = (state_q == FAULT);
    assign bus_io.fault_code = code_q;
    assign bus_io.gap        = gap_q;
endmodule

// File: tb/tb_tick_watchdog.sv
// Bench for tick_watchdog: two instances (FCNT_W 8 and 4) share one stimulus stream;
// a time-stamp based model predicts every output after every clock edge.
module tb_tick_watchdog;
    localparam int MinGap = 746;
    localparam int MaxGap = 756;
    localparam int Cbits  = 10;

`ifdef TICK_WDOG_EARLY_CHECK_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_r = 1'b0;
    logic clr_r = 1'b0;

    always #5 clk = ~clk;

    tick_watchdog_if #(.CBITS(Cbits), .FCNT_W(8)) bus8 ();
    tick_watchdog_if #(.CBITS(Cbits), .FCNT_W(4)) bus4 ();

    assign bus8.tick = tick_r;
    assign bus8.clr  = clr_r;
    assign bus4.tick = tick_r;
    assign bus4.clr  = clr_r;

    tick_watchdog #(
        .MIN_GAP (MinGap),
        .MAX_GAP (MaxGap),
        .CBITS   (Cbits),
        .FCNT_W  (8)
    ) dut8 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus8)
    );

    tick_watchdog #(
        .MIN_GAP (MinGap),
        .MAX_GAP (MaxGap),
        .CBITS   (Cbits),
        .FCNT_W  (4)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus4)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: edge counter, armed/faulted flags and the edge of the last accepted tick.
    int n      = 0;
    bit m_run  = 0;
    bit m_flt  = 0;
    int t_last = 0;
    int m_gap  = 0;
    int m_code = 0;
    int m_fc8  = 0;
    int m_fc4  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic enter_fault(input int code);
        m_run  = 0;
        m_flt  = 1;
        m_code = code;
        m_fc8  = (m_fc8 < 255) ? m_fc8 + 1 : 255;
        m_fc4  = (m_fc4 < 15) ? m_fc4 + 1 : 15;
    endtask

    task automatic model_edge(input bit tk, input bit cl, input bit rs);
        int g;
        if (rs) begin
            m_run = 0; m_flt = 0; m_gap = 0; m_code = 0; m_fc8 = 0; m_fc4 = 0;
        end else if (m_flt) begin
            if (cl) begin
                m_flt  = 0;
                m_code = 0;
            end
        end else if (!m_run) begin
            if (tk) begin
                m_run  = 1;
                t_last = n;
            end
        end else begin
            g = n - t_last;
            if (tk && EarlyEn && g < MinGap) begin
                enter_fault(2);
            end else if (tk) begin
                m_gap  = g;
                t_last = n;
            end else if (g == MaxGap) begin
                enter_fault(1);
            end
        end
    endtask

    task automatic check_all();
        check_val("d8.ok", int'(bus8.ok), int'(m_run));
        check_val("d8.fault", int'(bus8.fault), int'(m_flt));
        check_val("d8.code", int'(bus8.fault_code), m_code);
        check_val("d8.fcnt", int'(bus8.fault_cnt), m_fc8);
        check_val("d8.gap", int'(bus8.gap), m_gap);
        check_val("d4.ok", int'(bus4.ok), int'(m_run));
        check_val("d4.fault", int'(bus4.fault), int'(m_flt));
        check_val("d4.code", int'(bus4.fault_code), m_code);
        check_val("d4.fcnt", int'(bus4.fault_cnt), m_fc4);
        check_val("d4.gap", int'(bus4.gap), m_gap);
    endtask

    task automatic cyc(input bit tk, input bit cl, input bit rs);
        tick_r = tk;
        clr_r  = cl;
        rst    = rs;
        @(posedge clk);
        n++;
        model_edge(tk, cl, rs);
        #1;
        check_all();
    endtask

    // g-1 quiet cycles then a tick; clr_odds > 0 sprinkles random clr pulses.
    task automatic gap_tick(input int g, input int clr_odds);
        for (int i = 1; i < g; i++) begin
            cyc(1'b0, (clr_odds > 0) && ($urandom_range(clr_odds - 1) == 0), 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        check_val("rst_ok", int'(bus8.ok), 0);
        check_val("rst_gap", int'(bus8.gap), 0);

        // Nominal period.
        cyc(1'b1, 1'b0, 1'b0);
        check_val("ok_after_first", int'(bus8.ok), 1);
        repeat (4) gap_tick(751, 0);
        check_val("gap_751", int'(bus8.gap), 751);
        check_val("fcnt_nominal", int'(bus8.fault_cnt), 0);

        // Window edges.
        gap_tick(MinGap, 0);
        check_val("gap_min", int'(bus8.gap), MinGap);
        gap_tick(MaxGap, 0);
        check_val("gap_max", int'(bus8.gap), MaxGap);

        // One cycle too late.
        repeat (MaxGap - 1) cyc(1'b0, 1'b0, 1'b0);
        check_val("late_pre", int'(bus8.fault), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("late_fault", int'(bus8.fault), 1);
        check_val("late_code", int'(bus8.fault_code), 1);
        check_val("late_fcnt", int'(bus8.fault_cnt), 1);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("tick_in_fault", int'(bus8.fault), 1);

        // clr and tick together: tick dropped, next tick arms.
        cyc(1'b1, 1'b1, 1'b0);
        check_val("clr_tick_ok", int'(bus8.ok), 0);
        check_val("clr_tick_fault", int'(bus8.fault), 0);
        check_val("clr_tick_code", int'(bus8.fault_code), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check_val("still_idle", int'(bus8.ok), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check_val("rearm_ok", int'(bus8.ok), 1);

        // Early tick.
        gap_tick(700, 0);
        check_val("early_code", int'(bus8.fault_code), EarlyEn ? 2 : 0);
        check_val("early_gap", int'(bus8.gap), EarlyEn ? MaxGap : 700);
        if (EarlyEn) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end

        // Random gaps around the window with stray clr pulses.
        repeat (20) begin
            gap_tick($urandom_range(765, 690), 64);
            if (m_flt) cyc(1'b0, 1'b1, 1'b0);
            if (!m_run) cyc(1'b1, 1'b0, 1'b0);
        end

        // Reset mid-RUN at cnt = 400 after a fresh legal tick.
        if (m_flt) cyc(1'b0, 1'b1, 1'b0);
        if (!m_run) cyc(1'b1, 1'b0, 1'b0);
        while (n + 1 - t_last < 750) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (399) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("midrst_ok", int'(bus8.ok), 0);
        check_val("midrst_fcnt", int'(bus8.fault_cnt), 0);
        check_val("midrst_gap", int'(bus8.gap), 0);
        repeat (1000) cyc(1'b0, 1'b0, 1'b0);
        check_val("silence_fault", int'(bus8.fault), 0);

        // Repeated late faults saturate the 4-bit counter.
        repeat (20) begin
            cyc(1'b1, 1'b0, 1'b0);
            repeat (MaxGap) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        check_val("sat_fcnt4", int'(bus4.fault_cnt), 15);
        check_val("sat_fcnt8", int'(bus8.fault_cnt), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
